// File: rtl/median_last_actor.sv
`default_nettype none
// ============================================================================
//  Module   : median_last_actor
//  Brief    : Terminal median stage; buffers residual pixels and picks the
//             pixel of the requested rank by parallel rank counting.
//  Revision : 1.0
// ============================================================================
module median_last_actor #(
   parameter int MAX_BUFF       = 16,
   parameter int BUFF_SIZE_BIT  = $clog2(MAX_BUFF) + 1,
   parameter int AVERAGE_SECOND = 0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [7:0]               in_px,
   output logic                     in_px_rd,
   input  logic                     in_px_empty,
   input  logic [7:0]               in_pivot,
   output logic                     in_pivot_rd,
   input  logic                     in_pivot_empty,
   input  logic [BUFF_SIZE_BIT-1:0] in_buff_size,
   output logic                     in_buff_size_rd,
   input  logic                     in_buff_size_empty,
   input  logic [BUFF_SIZE_BIT-1:0] in_median_pos,
   output logic                     in_median_pos_rd,
   input  logic                     in_median_pos_empty,
   input  logic [7:0]               in_second_median_value,
   output logic                     in_second_median_value_rd,
   input  logic                     in_second_median_value_empty,
   output logic [7:0]               out_median,
   output logic                     out_median_wr,
   input  logic                     out_median_full
);

   localparam int IDX_W = (MAX_BUFF > 1) ? $clog2(MAX_BUFF) : 1;
   localparam logic [BUFF_SIZE_BIT-1:0] c_max_buff = BUFF_SIZE_BIT'(MAX_BUFF);
   localparam logic [BUFF_SIZE_BIT-1:0] c_one      = BUFF_SIZE_BIT'(1);
   localparam logic [IDX_W-1:0]         c_idx_one  = IDX_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_SELECT = 2'd2,
      ST_OUT    = 2'd3
   } state_t;

   state_t                   r_state;
   logic [7:0]               r_buf [MAX_BUFF];
   logic [7:0]               r_second;
   logic [7:0]               r_median;
   logic [BUFF_SIZE_BIT-1:0] r_n;
   logic [BUFF_SIZE_BIT-1:0] r_k;
   logic [BUFF_SIZE_BIT-1:0] r_issued;
   logic [BUFF_SIZE_BIT-1:0] r_cnt;
   logic [IDX_W-1:0]         r_cand;
   logic                     r_px_vld;

   logic                     w_tok_avail;
   logic                     w_tok_take;
   logic                     w_buf_we;
   logic [BUFF_SIZE_BIT-1:0] w_m;
   logic [BUFF_SIZE_BIT-1:0] w_k1;
   logic [BUFF_SIZE_BIT-1:0] w_rank;
   logic [BUFF_SIZE_BIT-1:0] w_lt;
   logic [BUFF_SIZE_BIT-1:0] w_eq;
   logic [7:0]               w_cand_px;
   logic                     w_hit;

   // Optional rounding average with the companion value, done in 9 bits.
   function automatic logic [7:0] final_value(input logic [7:0] v, input logic [7:0] s);
      logic [8:0] sum;
      sum = {1'b0, v} + {1'b0, s} + 9'd1;
      return (AVERAGE_SECOND != 0) ? sum[8:1] : v;
   endfunction

   // All four control tokens are taken together, never one at a time.
   assign w_tok_avail = ~in_pivot_empty & ~in_buff_size_empty &
                        ~in_median_pos_empty & ~in_second_median_value_empty;
   assign w_tok_take  = reset & (r_state == ST_IDLE) & w_tok_avail;

   assign in_pivot_rd               = w_tok_take;
   assign in_buff_size_rd           = w_tok_take;
   assign in_median_pos_rd          = w_tok_take;
   assign in_second_median_value_rd = w_tok_take;

   assign in_px_rd      = (r_state == ST_FILL) & ~in_px_empty & (r_issued < r_n);
   assign out_median_wr = (r_state == ST_OUT) & ~out_median_full;
   assign out_median    = r_median;

   assign w_buf_we  = (r_state == ST_FILL) & r_px_vld & (r_cnt < c_max_buff);
   assign w_m       = (r_n > c_max_buff) ? c_max_buff : r_n;
   assign w_k1      = (r_k == '0) ? c_one : r_k;
   assign w_rank    = ((w_k1 > w_m) ? w_m : w_k1) - c_one;
   assign w_cand_px = r_buf[r_cand];

   // Rank of the current candidate against every valid buffer entry.
   always_comb begin
      w_lt = '0;
      w_eq = '0;
      for (int j = 0; j < MAX_BUFF; j++) begin
         if (BUFF_SIZE_BIT'(j) < w_m) begin
            if (r_buf[j] < w_cand_px)  w_lt = w_lt + c_one;
            if (r_buf[j] == w_cand_px) w_eq = w_eq + c_one;
         end
      end
   end

   assign w_hit = (w_lt <= w_rank) && (w_rank < (w_lt + w_eq));

   always_ff @(posedge clock) begin
      if (w_buf_we) r_buf[r_cnt[IDX_W-1:0]] <= in_px;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_second <= '0;
         r_median <= '0;
         r_n      <= '0;
         r_k      <= '0;
         r_issued <= '0;
         r_cnt    <= '0;
         r_cand   <= '0;
         r_px_vld <= 1'b0;
      end else begin
         r_px_vld <= in_px_rd & ~in_px_empty;
         case (r_state)
            ST_IDLE: begin
               if (w_tok_take) begin
                  r_n      <= in_buff_size;
                  r_k      <= in_median_pos;
                  r_second <= in_second_median_value;
                  r_issued <= '0;
                  r_cnt    <= '0;
                  if (in_buff_size == '0) begin
                     r_median <= final_value(in_pivot, in_second_median_value);
                     r_state  <= ST_OUT;
                  end else begin
                     r_state  <= ST_FILL;
                  end
               end
            end
            ST_FILL: begin
               if (in_px_rd) r_issued <= r_issued + c_one;
               // Pixels past the buffer capacity are counted but dropped.
               if (r_px_vld) begin
                  r_cnt <= r_cnt + c_one;
                  if ((r_cnt + c_one) == r_n) begin
                     r_cand  <= '0;
                     r_state <= ST_SELECT;
                  end
               end
            end
            ST_SELECT: begin
               if (w_hit) begin
                  r_median <= final_value(w_cand_px, r_second);
                  r_state  <= ST_OUT;
               end else begin
                  r_cand   <= r_cand + c_idx_one;
               end
            end
            ST_OUT: begin
               if (!out_median_full) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
